// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared state, opcode, branch-condition and mux-select encodings for mc_control_unit
package mc_ctrl_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_RESET_PC = 3'd0;
  localparam state_t S_IDLE     = 3'd1;
  localparam state_t S_FETCH    = 3'd2;
  localparam state_t S_DECODE   = 3'd3;
  localparam state_t S_EXEC     = 3'd4;
  localparam state_t S_MEM      = 3'd5;
  localparam state_t S_WB       = 3'd6;
  localparam state_t S_HALT     = 3'd7;
  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_LHI  = 5'b00001;
  localparam logic [4:0] OP_LLI  = 5'b00010;
  localparam logic [4:0] OP_LDRI = 5'b00011;
  localparam logic [4:0] OP_LDRR = 5'b00100;
  localparam logic [4:0] OP_STRI = 5'b00101;
  localparam logic [4:0] OP_STRR = 5'b00110;
  localparam logic [4:0] OP_CMP  = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b00111;
  localparam logic [4:0] OP_SUBI = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01011;
  localparam logic [3:0] OP_BR   = 4'b1100;
  localparam logic [4:0] OP_JMP  = 5'b10000;
  localparam logic [4:0] OP_JAL  = 5'b10001;
  localparam logic [4:0] OP_JALR = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_HLT  = 5'b11100;
  localparam logic [4:0] OP_OUTR = 5'b11100;
  localparam logic [1:0] SUB_STR  = 2'b00;
  localparam logic [1:0] SUB_CMP  = 2'b01;
  localparam logic [1:0] SUB_OUTR = 2'b00;
  localparam logic [1:0] SUB_HLT  = 2'b01;
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [1:0] PC_SEL_INC = 2'b00;
  localparam logic [1:0] PC_SEL_JMP = 2'b01;
  localparam logic [1:0] PC_SEL_REG = 2'b10;
  localparam logic [1:0] PC_SEL_CLR = 2'b11;
  localparam logic [1:0] IMM_SEL_LO  = 2'b00;
  localparam logic [1:0] IMM_SEL_LLI = 2'b10;
  localparam logic [1:0] IMM_SEL_LHI = 2'b11;
  localparam logic [1:0] ALU_B_REG = 2'b00;
  localparam logic [1:0] ALU_B_IMM = 2'b01;
  localparam logic [1:0] ALU_B_MOV = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] WD_MEM = 2'b00;
  localparam logic [1:0] WD_IMM = 2'b01;
  localparam logic [1:0] WD_ALU = 2'b10;
  localparam logic [1:0] WD_PC  = 2'b11;
endpackage

// File: rtl/mc_control_unit_if.sv
// mc_control_unit_if: decoded instruction fields/flags from the datapath and every datapath control input
interface mc_control_unit_if;
  logic [4:0] Opcode;
  logic [2:0] Rd_Addr;
  logic [1:0] ALU_Op;
  logic Z_Reg, C_Reg;
  logic PC_CE, PC_Add_Src, PC_ALU_Sel, IR_CE, Rd_Reg_CE, ALUOut_Reg_CE, Z_CE, C_CE;
  logic RF_Write_en, MemW_en, Rd_Rm_Sel, Out_R_CE, Mem_Addr_Sel, MemW_Data_Sel;
  logic [1:0] PC_Sel, Imm_Sel, ALU_B_Sel, ALU_Control, RF_Write_Data_Sel;
  modport master (
    input  Opcode, Rd_Addr, ALU_Op, Z_Reg, C_Reg,
    output PC_CE, PC_Add_Src, PC_ALU_Sel, IR_CE, Rd_Reg_CE, ALUOut_Reg_CE, Z_CE, C_CE,
    output RF_Write_en, MemW_en, Rd_Rm_Sel, Out_R_CE, Mem_Addr_Sel, MemW_Data_Sel,
    output PC_Sel, Imm_Sel, ALU_B_Sel, ALU_Control, RF_Write_Data_Sel
  );
  modport slave (
    output Opcode, Rd_Addr, ALU_Op, Z_Reg, C_Reg,
    input  PC_CE, PC_Add_Src, PC_ALU_Sel, IR_CE, Rd_Reg_CE, ALUOut_Reg_CE, Z_CE, C_CE,
    input  RF_Write_en, MemW_en, Rd_Rm_Sel, Out_R_CE, Mem_Addr_Sel, MemW_Data_Sel,
    input  PC_Sel, Imm_Sel, ALU_B_Sel, ALU_Control, RF_Write_Data_Sel
  );
endinterface

// File: rtl/mc_branch_eval.sv
// mc_branch_eval: combinational branch-condition evaluation; unlisted conditions are never taken
module mc_branch_eval
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic       i_z,
  input  logic       i_c,
  output logic       o_taken
);
  assign o_taken = i_cond == COND_EQ ? i_z :
                   i_cond == COND_NE ? !i_z :
                   i_cond == COND_CS ? i_c :
                   i_cond == COND_CC ? !i_c :
                   i_cond == COND_AL;
endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle control FSM with run/halt control and retired-instruction counter.
// Define SINGLE_STEP_EN to require a Step pulse per instruction.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Run,
  input  logic             Step,
  mc_control_unit_if.master bus,
  output logic             Halted,
  output logic             Busy,
  output logic [CNT_W-1:0] Instr_Count
);
  if (RESET_PC != 0) begin : g_bad_reset_pc
    $error("mc_control_unit: only RESET_PC=0 is supported");
  end
  state_t r_state, w_next, w_after;
  logic [CNT_W-1:0] r_count;
  logic [4:0] w_op;
  logic w_lhi, w_lli, w_alu, w_addi, w_subi, w_cmp, w_mov, w_ldr, w_str, w_br;
  logic w_jmp, w_jal_l, w_jal_r, w_jr, w_outr, w_hlt;
  logic w_alu_cls, w_mem_cls, w_flag_cls, w_taken, w_retire, w_go;
  logic w_rpc, w_fetch, w_dec, w_exec, w_mem, w_wb, w_held;
  assign w_op    = bus.Opcode;
  assign w_lhi   = w_op == OP_LHI;
  assign w_lli   = w_op == OP_LLI;
  assign w_alu   = w_op == OP_ALU;
  assign w_addi  = w_op == OP_ADDI;
  assign w_subi  = w_op == OP_SUBI;
  assign w_cmp   = w_op == OP_CMP && bus.ALU_Op == SUB_CMP;
  assign w_mov   = w_op == OP_MOV;
  assign w_ldr   = w_op == OP_LDRI || w_op == OP_LDRR;
  assign w_str   = w_op == OP_STRI || (w_op == OP_STRR && bus.ALU_Op == SUB_STR);
  assign w_br    = w_op[4:1] == OP_BR;
  assign w_jmp   = w_op == OP_JMP;
  assign w_jal_l = w_op == OP_JAL;
  assign w_jal_r = w_op == OP_JALR;
  assign w_jr    = w_op == OP_JR;
  assign w_outr  = w_op == OP_OUTR && bus.ALU_Op == SUB_OUTR;
  assign w_hlt   = w_op == OP_HLT && bus.ALU_Op == SUB_HLT;
  assign w_alu_cls  = w_alu || w_addi || w_subi || w_mov;
  assign w_flag_cls = w_alu || w_addi || w_subi || w_cmp;
  assign w_mem_cls  = w_ldr || w_str;
  mc_branch_eval u_branch_eval (
    .i_cond  ({w_op[0], bus.Rd_Addr}),
    .i_z     (bus.Z_Reg),
    .i_c     (bus.C_Reg),
    .o_taken (w_taken)
  );
`ifdef SINGLE_STEP_EN
  assign w_go    = Run && Step;
  assign w_after = S_IDLE;
`else
  logic w_unused_step;
  assign w_unused_step = Step;
  assign w_go    = Run;
  assign w_after = Run ? S_FETCH : S_IDLE;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET_PC:  w_next = S_IDLE;
      S_IDLE:      w_next = w_go ? S_FETCH : S_IDLE;
      S_FETCH:     w_next = S_DECODE;
      S_DECODE:    w_next = (w_lhi || w_lli) ? S_WB : S_EXEC;
      S_EXEC:      w_next = w_alu_cls ? S_WB : w_mem_cls ? S_MEM : w_hlt ? S_HALT : w_after;
      S_MEM, S_WB: w_next = w_after;
      default:     w_next = S_HALT;
    endcase
  end
  assign w_retire = (r_state == S_EXEC && !w_alu_cls && !w_mem_cls) || r_state == S_MEM || r_state == S_WB;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RESET_PC;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_count <= r_count + 1'b1;
    end
  end
  // the reset state still decodes while rst_n is low, so it alone is gated by rst_n
  assign w_rpc   = rst_n && r_state == S_RESET_PC;
  assign w_fetch = r_state == S_FETCH;
  assign w_dec   = r_state == S_DECODE;
  assign w_exec  = r_state == S_EXEC;
  assign w_mem   = r_state == S_MEM;
  assign w_wb    = r_state == S_WB;
  assign w_held  = w_dec || w_exec || w_mem || w_wb;
  assign bus.PC_CE = w_rpc || w_fetch || (w_exec && (w_br ? w_taken : (w_jmp || w_jal_l || w_jal_r || w_jr)));
  assign bus.PC_Add_Src = w_exec && ((w_br && w_taken) || w_jal_l);
  assign bus.PC_Sel = w_rpc ? PC_SEL_CLR :
                      (w_exec && w_jmp) ? PC_SEL_JMP :
                      (w_exec && (w_jr || w_jal_r)) ? PC_SEL_REG : PC_SEL_INC;
  assign bus.PC_ALU_Sel    = w_mem;
  assign bus.IR_CE         = w_fetch;
  assign bus.Rd_Reg_CE     = w_dec;
  assign bus.ALUOut_Reg_CE = w_exec && (w_alu_cls || w_mem_cls);
  assign bus.Z_CE          = w_exec && w_flag_cls;
  assign bus.C_CE          = w_exec && w_flag_cls;
  assign bus.RF_Write_en   = w_wb || (w_mem && w_ldr) || (w_exec && (w_jal_l || w_jal_r));
  assign bus.MemW_en       = w_mem && w_str;
  assign bus.Rd_Rm_Sel     = w_held && (w_mem_cls || w_jal_r || w_outr);
  assign bus.Out_R_CE      = w_exec && w_outr;
  assign bus.Mem_Addr_Sel  = 1'b0;
  assign bus.MemW_Data_Sel = 1'b0;
  assign bus.Imm_Sel = (w_held && w_lhi) ? IMM_SEL_LHI : (w_held && w_lli) ? IMM_SEL_LLI : IMM_SEL_LO;
  assign bus.ALU_B_Sel = !w_exec ? ALU_B_REG :
                         w_mov ? ALU_B_MOV :
                         (w_addi || w_subi || (w_mem_cls && w_op[0])) ? ALU_B_IMM : ALU_B_REG;
  assign bus.ALU_Control = !w_exec ? ALU_ADD : w_alu ? bus.ALU_Op : (w_subi || w_cmp) ? ALU_SUB : ALU_ADD;
  assign bus.RF_Write_Data_Sel = w_wb ? ((w_lhi || w_lli) ? WD_IMM : WD_ALU) :
                                 (w_exec && (w_jal_l || w_jal_r)) ? WD_PC : WD_MEM;
  assign Halted      = r_state == S_HALT;
  assign Busy        = rst_n && r_state != S_IDLE && r_state != S_HALT;
  assign Instr_Count = r_count;
endmodule
